// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/divide unit for a MIPS-style pipeline.
// The result is computed at issue and held in a pending register, then
// committed to HI/LO when the busy window expires.
// Optional feature macro: MULDIV_MADD_EN enables madd/msub on md_op 6/7.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_pendHi, r_pendLo;

  state_t      w_nextState;
  logic [3:0]  w_nextCount;
  logic        w_capture, w_commit, w_writeHi, w_writeLo;
  logic        w_isMul, w_isDiv, w_signedDiv;
  logic [63:0] w_sProd, w_uProd;
  logic [31:0] w_dividend, w_divisor, w_divisorSafe;
  logic [31:0] w_qMag, w_rMag, w_quot, w_rem;
  logic [31:0] w_pendHi, w_pendLo;

  assign busy = (r_state != IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

`ifdef MULDIV_MADD_EN
  assign w_isMul = (md_op == 3'd0) || (md_op == 3'd1) || (md_op == 3'd6) || (md_op == 3'd7);
`else
  assign w_isMul = (md_op == 3'd0) || (md_op == 3'd1);
`endif
  assign w_isDiv     = (md_op == 3'd2) || (md_op == 3'd3);
  assign w_signedDiv = (md_op == 3'd2);

  // Products and sign/magnitude division; the divisor is forced nonzero so the
  // divider never sees zero, the zero case is handled when choosing pending.
  always_comb begin
    w_sProd       = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    w_uProd       = {32'd0, a} * {32'd0, b};
    w_dividend    = (w_signedDiv && a[31]) ? (~a + 32'd1) : a;
    w_divisor     = (w_signedDiv && b[31]) ? (~b + 32'd1) : b;
    w_divisorSafe = (w_divisor == 32'd0) ? 32'd1 : w_divisor;
    w_qMag        = w_dividend / w_divisorSafe;
    w_rMag        = w_dividend % w_divisorSafe;
    w_quot        = (w_signedDiv && (a[31] ^ b[31])) ? (~w_qMag + 32'd1) : w_qMag;
    w_rem         = (w_signedDiv && a[31]) ? (~w_rMag + 32'd1) : w_rMag;
  end

  // Select the value to park in pending; divide by zero parks the current HI/LO.
  always_comb begin
    w_pendHi = r_hi;
    w_pendLo = r_lo;
    case (md_op)
      3'd0: {w_pendHi, w_pendLo} = w_sProd;
      3'd1: {w_pendHi, w_pendLo} = w_uProd;
      3'd2, 3'd3: begin
        if (b != 32'd0) begin
          w_pendHi = w_rem;
          w_pendLo = w_quot;
        end
      end
`ifdef MULDIV_MADD_EN
      3'd6: {w_pendHi, w_pendLo} = {r_hi, r_lo} + w_sProd;
      3'd7: {w_pendHi, w_pendLo} = {r_hi, r_lo} - w_sProd;
`endif
      default: ;
    endcase
  end

  // Next-state logic: accept issue only in IDLE, count down the busy window.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    w_writeHi   = 1'b0;
    w_writeLo   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_isMul) begin
            w_nextState = MUL;
            w_nextCount = 4'(MULT_CYCLES);
            w_capture   = 1'b1;
          end else if (w_isDiv) begin
            w_nextState = DIV;
            w_nextCount = 4'(DIV_CYCLES);
            w_capture   = 1'b1;
          end else if (md_op == 3'd4) begin
            w_writeHi = 1'b1;
          end else if (md_op == 3'd5) begin
            w_writeLo = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        w_nextCount = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_nextState = IDLE;
          w_commit    = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // Pending capture and HI/LO updates (commit, mthi, mtlo).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pendHi <= 32'd0;
      r_pendLo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      if (w_capture) begin
        r_pendHi <= w_pendHi;
        r_pendLo <= w_pendLo;
      end
      if (w_commit) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
      if (w_writeHi) r_hi <= a;
      if (w_writeLo) r_lo <= a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an
// arithmetic reference model of HI/LO.
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int          nAssert = 0;
  int          nFail   = 0;
  logic [31:0] hiM, loM;

  muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int expCycles(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return MULT_N;
      3'd2, 3'd3: return DIV_N;
`ifdef MULDIV_MADD_EN
      3'd6, 3'd7: return MULT_N;
`endif
      default: return 0;
    endcase
  endfunction

  // Reference model: architectural effect of one operation on HI/LO.
  task automatic modelOp(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (op)
      3'd0: begin p = 64'(sx * sy); {hiM, loM} = p; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; {hiM, loM} = p; end
      3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; loM = 32'(q); hiM = 32'(r); end
      3'd3: if (y != 0) begin q = ux / uy; r = ux % uy; loM = 32'(q); hiM = 32'(r); end
      3'd4: hiM = x;
      3'd5: loM = x;
`ifdef MULDIV_MADD_EN
      3'd6: begin p = {hiM, loM} + 64'(sx * sy); {hiM, loM} = p; end
      3'd7: begin p = {hiM, loM} - 64'(sx * sy); {hiM, loM} = p; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op (called at #1 after a rising edge with the unit idle), then
  // count busy cycles while checking that HI/LO hold during the window.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] x,
                               input logic [31:0] y, output int cyc);
    logic [31:0] preHi, preLo;
    preHi = hi;
    preLo = lo;
    start = 1'b1; md_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 40) begin
      checkOutput({tag, " hold hi"}, hi, preHi);
      checkOutput({tag, " hold lo"}, lo, preLo);
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int cyc;
    applyStimulus(tag, op, x, y, cyc);
    modelOp(op, x, y);
    checkOutput({tag, " busy cycles"}, 32'(cyc), 32'(expCycles(op)));
    checkOutput({tag, " hi"}, hi, hiM);
    checkOutput({tag, " lo"}, lo, loM);
  endtask

  initial begin
    int          cyc;
    logic [2:0]  op;
    logic [31:0] x, y;

    reset = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    hiM = 32'd0; loM = 32'd0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Signed and unsigned multiply of 0xFFFFFFFF * 2.
    runOp("mult", 3'd0, 32'hFFFF_FFFF, 32'd2);
    checkOutput("mult hi const", hi, 32'hFFFF_FFFF);
    checkOutput("mult lo const", lo, 32'hFFFF_FFFE);
    runOp("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
    checkOutput("multu hi const", hi, 32'h0000_0001);
    checkOutput("multu lo const", lo, 32'hFFFF_FFFE);

    // Signed divide -7/2, divide by zero, overflow corner.
    runOp("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div lo const", lo, 32'hFFFF_FFFD);
    checkOutput("div hi const", hi, 32'hFFFF_FFFF);
    runOp("divu0", 3'd3, 32'd7, 32'd0);
    checkOutput("divu0 hi const", hi, 32'hFFFF_FFFF);
    checkOutput("divu0 lo const", lo, 32'hFFFF_FFFD);
    runOp("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("divovf lo const", lo, 32'h8000_0000);
    checkOutput("divovf hi const", hi, 32'h0000_0000);

    // mtlo: immediate write, never busy.
    runOp("mtlo", 3'd5, 32'h1234_5678, 32'd0);
    checkOutput("mtlo lo const", lo, 32'h1234_5678);

    // Second start during a mult busy window must be ignored.
    start = 1'b1; md_op = 3'd0; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd4; a = 32'hDEAD_BEEF; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    while (busy && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
    modelOp(3'd0, 32'd6, 32'd7);
    checkOutput("ignored busy cycles", 32'(cyc), 32'(MULT_N + 1));
    checkOutput("ignored hi", hi, 32'd0);
    checkOutput("ignored lo", lo, 32'd42);

    // Reset in the third cycle of a divide.
    runOp("mthi pre", 3'd4, 32'hCAFE_0001, 32'd0);
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset hi", hi, 32'd0);
    checkOutput("midreset lo", lo, 32'd0);
    #2;
    reset = 1'b1;
    hiM = 32'd0; loM = 32'd0;
    runOp("postreset div", 3'd2, 32'd100, 32'd7);
    checkOutput("postreset lo const", lo, 32'd14);
    checkOutput("postreset hi const", hi, 32'd2);

    // madd with hi=0, lo=5.
    runOp("mthi0", 3'd4, 32'd0, 32'd0);
    runOp("mtlo5", 3'd5, 32'd5, 32'd0);
    runOp("madd", 3'd6, 32'd3, 32'd4);
`ifdef MULDIV_MADD_EN
    checkOutput("madd lo const", lo, 32'd17);
`else
    checkOutput("madd lo const", lo, 32'd5);
`endif

    // Random operations against the model.
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
      runOp($sformatf("rand%0d op%0d", i, op), op, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
